dac_spi_driver: RTL and testbench

- Serialises the 10-bit processed sample from the echo processor into a 16-bit SPI write frame for an MCP4911-class 10-bit DAC.
- Sits directly downstream of the processor stage:
  - takes its registered `data_out` and the same 10 kHz sample `pulse`;
  - drives the DAC pins `SDI`, `SCK`, `CS_n` and `LDAC_n`.
- Holds one pending sample so a sample pulse arriving mid-frame is not lost.

---
 rtl/dac_spi_driver.sv | 190 +++++++++++++++++++
 tb/tb_dac_spi_driver.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_spi_driver.sv
`default_nettype none
// ============================================================================
//  Module      : dac_spi_driver
//  Description : Builds a 16-bit write frame for an MCP4911-class 10-bit DAC
//                from a processed sample. Shifts the frame out MSB first over
//                SPI (mode 0, SCK idles low), then pulses LDAC to update the
//                DAC output. One sample can wait in a pending register, so a
//                strobe that arrives mid-frame is not lost.
//  Ports       : sysclk   - system clock, rising edge only
//                reset_n  - asynchronous active-low reset
//                data_in  - 10-bit offset-binary sample
//                load     - sample strobe, active high
//                dac_sdi  - SPI data, MSB first
//                dac_sck  - SPI clock, idle low
//                dac_cs   - chip select, active low
//                dac_ld   - LDAC, active low, one pulse per frame
//                busy     - frame or LDAC pulse in progress
//                done     - one-cycle pulse at frame completion
//  Revision    : 1.0 - initial release
// ============================================================================
module dac_spi_driver #(
    parameter int CLK_DIV = 25,   // sysclk cycles per SCK half-period, 1..255
    parameter bit BUF     = 1'b0, // frame bit 14, VREF buffer enable
    parameter bit GA_N    = 1'b1  // frame bit 13, 1 = gain 1x
) (
    input  logic       sysclk,
    input  logic       reset_n,
    input  logic [9:0] data_in,
    input  logic       load,
    output logic       dac_sdi,
    output logic       dac_sck,
    output logic       dac_cs,
    output logic       dac_ld,
    output logic       busy,
    output logic       done
);

    localparam int             c_DIV_W    = 8;
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_STOP  = 2'd2;
    localparam logic [1:0] S_LDAC  = 2'd3;

    logic [1:0]         state_q,      state_d;
    logic [c_DIV_W-1:0] div_q,        div_d;
    logic [3:0]         bit_q,        bit_d;
    logic [15:0]        shreg_q,      shreg_d;
    logic               sck_q,        sck_d;
    logic               sdi_q,        sdi_d;
    logic               cs_q,         cs_d;
    logic               ld_q,         ld_d;
    logic               busy_q,       busy_d;
    logic               done_q,       done_d;
    logic               pend_valid_q, pend_valid_d;
    logic [9:0]         pend_data_q,  pend_data_d;

    logic               w_div_end;
    logic [15:0]        w_frame;

    function automatic logic [15:0] build_frame(input logic [9:0] d);
        return {1'b0, BUF, GA_N, 1'b1, d, 2'b00};
    endfunction

    assign w_div_end = (div_q == c_DIV_LAST);

    // A fresh strobe in IDLE takes priority over the pending word.
    assign w_frame = load ? build_frame(data_in) : build_frame(pend_data_q);

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            div_q        <= '0;
            bit_q        <= '0;
            shreg_q      <= '0;
            sck_q        <= 1'b0;
            sdi_q        <= 1'b0;
            cs_q         <= 1'b1;
            ld_q         <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            div_q        <= div_d;
            bit_q        <= bit_d;
            shreg_q      <= shreg_d;
            sck_q        <= sck_d;
            sdi_q        <= sdi_d;
            cs_q         <= cs_d;
            ld_q         <= ld_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pend_valid_q <= pend_valid_d;
            pend_data_q  <= pend_data_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (load || pend_valid_q)                 state_d = S_SHIFT;
            S_SHIFT: if (w_div_end && sck_q && (bit_q == 4'd0)) state_d = S_STOP;
            S_STOP:  if (w_div_end)                            state_d = S_LDAC;
            S_LDAC:  if (w_div_end)                            state_d = S_IDLE;
            default:                                           state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath and output-register next values
    // ------------------------------------------------------------------------
    always_comb begin
        div_d        = div_q;
        bit_d        = bit_q;
        shreg_d      = shreg_q;
        sck_d        = sck_q;
        sdi_d        = sdi_q;
        pend_valid_d = pend_valid_q;
        pend_data_d  = pend_data_q;

        // Pin levels follow the state being entered, so they change on the
        // same edge as the transition and stay registered.
        cs_d   = (state_d != S_SHIFT);
        ld_d   = (state_d != S_LDAC);
        busy_d = (state_d != S_IDLE);
        done_d = (state_q == S_LDAC) && (state_d == S_IDLE);

        case (state_q)
            S_IDLE: begin
                div_d = '0;
                sck_d = 1'b0;
                if (load || pend_valid_q) begin
                    shreg_d      = w_frame;
                    sdi_d        = w_frame[15];
                    bit_d        = 4'd15;
                    pend_valid_d = 1'b0;
                end
            end
            S_SHIFT: begin
                if (w_div_end) begin
                    div_d = '0;
                    if (!sck_q) begin
                        sck_d = 1'b1;
                    end else begin
                        // End of a bit cell: SCK falls and, unless this was
                        // bit 0, the next bit is presented while SCK is low.
                        sck_d = 1'b0;
                        if (bit_q != 4'd0) begin
                            bit_d   = bit_q - 4'd1;
                            shreg_d = {shreg_q[14:0], shreg_q[15]};
                            sdi_d   = shreg_q[14];
                        end
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            S_STOP, S_LDAC: begin
                div_d = w_div_end ? '0 : div_q + 1'b1;
            end
            default: begin
                div_d = '0;
            end
        endcase

        // Strobes outside IDLE park in the pending register; the last wins.
        if ((state_q != S_IDLE) && load) begin
            pend_valid_d = 1'b1;
            pend_data_d  = data_in;
        end
    end

    assign dac_sdi = sdi_q;
    assign dac_sck = sck_q;
    assign dac_cs  = cs_q;
    assign dac_ld  = ld_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule
`default_nettype wire

// File: tb/tb_dac_spi_driver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dac_spi_driver
//  Description : Self-checking bench for dac_spi_driver. Three instances:
//                index 0 CLK_DIV=2, index 1 CLK_DIV=1 with BUF=1/GA_N=0,
//                index 2 default parameters. A negedge SPI monitor rebuilds
//                frames and timing; a cycle-level model predicts the frames
//                for randomized strobe traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dac_spi_driver;

    localparam int LOGN = 256;

    logic       clk;
    logic       rst_n;
    logic [2:0] load_r;
    logic [9:0] din_r [3];
    logic [2:0] sdi_w, sck_w, cs_w, ld_w, busy_w, done_w;

    int n_cmp;
    int n_bad;
    int cyc;

    // Monitor state
    logic [15:0] m_sh      [3];
    int          m_bits    [3];
    int          m_cslen   [3];
    int          m_ldlen   [3];
    logic [2:0]  p_cs, p_sck, p_ld, p_done;
    int          cs_fall   [3];
    int          first_rise[3];
    int          frame_cnt [3];
    int          done_cnt  [3];
    int          done_long [3];
    int          ld_len_last[3];
    logic [15:0] frame_log [3][LOGN];
    int          bits_log  [3][LOGN];
    int          cslen_log [3][LOGN];
    int          fall_log  [3][LOGN];
    int          rise_log  [3][LOGN];
    int          done_log  [3][LOGN];
    logic [2:0]  done_busy;

    dac_spi_driver #(.CLK_DIV(2)) u_dut0 (
        .sysclk(clk), .reset_n(rst_n), .data_in(din_r[0]), .load(load_r[0]),
        .dac_sdi(sdi_w[0]), .dac_sck(sck_w[0]), .dac_cs(cs_w[0]),
        .dac_ld(ld_w[0]), .busy(busy_w[0]), .done(done_w[0]));

    dac_spi_driver #(.CLK_DIV(1), .BUF(1'b1), .GA_N(1'b0)) u_dut1 (
        .sysclk(clk), .reset_n(rst_n), .data_in(din_r[1]), .load(load_r[1]),
        .dac_sdi(sdi_w[1]), .dac_sck(sck_w[1]), .dac_cs(cs_w[1]),
        .dac_ld(ld_w[1]), .busy(busy_w[1]), .done(done_w[1]));

    dac_spi_driver u_dut2 (
        .sysclk(clk), .reset_n(rst_n), .data_in(din_r[2]), .load(load_r[2]),
        .dac_sdi(sdi_w[2]), .dac_sck(sck_w[2]), .dac_cs(cs_w[2]),
        .dac_ld(ld_w[2]), .busy(busy_w[2]), .done(done_w[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // SPI monitor, sampling away from the active edge
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                m_sh[i]    <= '0;
                m_bits[i]  <= 0;
                m_cslen[i] <= 0;
                m_ldlen[i] <= 0;
                p_cs[i]    <= 1'b1;
                p_sck[i]   <= 1'b0;
                p_ld[i]    <= 1'b1;
                p_done[i]  <= 1'b0;
            end else begin
                if (!cs_w[i]) begin
                    if (p_cs[i]) cs_fall[i] <= cyc;
                    m_cslen[i] <= m_cslen[i] + 1;
                    if (sck_w[i] && !p_sck[i]) begin
                        m_sh[i]   <= {m_sh[i][14:0], sdi_w[i]};
                        m_bits[i] <= m_bits[i] + 1;
                        if (m_bits[i] == 0) first_rise[i] <= cyc;
                    end
                end else if (!p_cs[i]) begin
                    if (frame_cnt[i] < LOGN) begin
                        frame_log[i][frame_cnt[i]] <= m_sh[i];
                        bits_log[i][frame_cnt[i]]  <= m_bits[i];
                        cslen_log[i][frame_cnt[i]] <= m_cslen[i];
                        fall_log[i][frame_cnt[i]]  <= cs_fall[i];
                        rise_log[i][frame_cnt[i]]  <= first_rise[i];
                    end
                    frame_cnt[i] <= frame_cnt[i] + 1;
                    m_sh[i]      <= '0;
                    m_bits[i]    <= 0;
                    m_cslen[i]   <= 0;
                end
                if (!ld_w[i]) begin
                    m_ldlen[i] <= m_ldlen[i] + 1;
                end else if (!p_ld[i]) begin
                    ld_len_last[i] <= m_ldlen[i];
                    m_ldlen[i]     <= 0;
                end
                if (done_w[i]) begin
                    if (done_cnt[i] < LOGN) done_log[i][done_cnt[i]] <= cyc;
                    done_cnt[i]  <= done_cnt[i] + 1;
                    done_busy[i] <= busy_w[i];
                    if (p_done[i]) done_long[i] <= done_long[i] + 1;
                end
                p_cs[i]   <= cs_w[i];
                p_sck[i]  <= sck_w[i];
                p_ld[i]   <= ld_w[i];
                p_done[i] <= done_w[i];
            end
        end
    end

    function automatic int cd_of(input int idx);
        case (idx)
            0:       return 2;
            1:       return 1;
            default: return 25;
        endcase
    endfunction

    // Expected frame from the DAC write-command layout
    function automatic logic [15:0] frame_of(input int idx, input logic [9:0] d);
        int v;
        v = 4096 + 4 * int'(d);
        if (idx == 1) v = v + 16384;   // BUF=1, GA_N=0
        else          v = v + 8192;    // BUF=0, GA_N=1
        return 16'(v);
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_done(input int idx, input int target, input int budget);
        int n;
        n = 0;
        while (done_cnt[idx] < target && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        if (done_cnt[idx] < target) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout dut%0d: done count %0d expected %0d", idx, done_cnt[idx], target);
        end
    endtask

    task automatic pulse_load(input int idx, input logic [9:0] d, output int s);
        @(negedge clk);
        load_r[idx] = 1'b1;
        din_r[idx]  = d;
        @(negedge clk);
        load_r[idx] = 1'b0;
        s = cyc;
    endtask

    task automatic run_single(input int idx, input logic [9:0] d, input logic [15:0] exp);
        int s, fc, dc, cd;
        cd = cd_of(idx);
        fc = frame_cnt[idx];
        dc = done_cnt[idx];
        pulse_load(idx, d, s);
        chk("start_cs", int'(cs_w[idx]), 0);
        chk("start_busy", int'(busy_w[idx]), 1);
        chk("start_sdi", int'(sdi_w[idx]), int'(exp[15]));
        wait_done(idx, dc + 1, 40 * cd + 20);
        chk("frame", int'(frame_log[idx][fc]), int'(exp));
        chk("bits", bits_log[idx][fc], 16);
        chk("cs_len", cslen_log[idx][fc], 32 * cd);
        chk("first_sck", rise_log[idx][fc] - s, cd);
        chk("ld_len", ld_len_last[idx], cd);
        chk("done_lat", done_log[idx][dc] - s, 34 * cd);
        chk("done_busy", int'(done_busy[idx]), 0);
    endtask

    typedef struct {
        int          dut;
        logic [9:0]  data;
        logic [15:0] exp;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int s, fc, dc, base_f, base_d, busy_until;
        bit pv, ld;
        logic [9:0] pd, d;
        logic [15:0] eq[$];
        logic [15:0] pq[$];

        n_cmp = 0; n_bad = 0;
        load_r = '0;
        for (int i = 0; i < 3; i++) din_r[i] = '0;

        tbl[0] = '{0, 10'h2A5, 16'h3A94};
        tbl[1] = '{0, 10'h000, 16'h3000};
        tbl[2] = '{0, 10'h3FF, 16'h3FFC};
        tbl[3] = '{0, 10'h155, 16'h3554};
        tbl[4] = '{1, 10'h3FF, 16'h5FFC};
        tbl[5] = '{1, 10'h000, 16'h5000};
        tbl[6] = '{1, 10'h2A5, 16'h5A94};
        tbl[7] = '{2, 10'h1C3, 16'h370C};

        // Reset state
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        chk("reset_pins", int'({cs_w[0], sck_w[0], sdi_w[0], ld_w[0], busy_w[0], done_w[0]}), 6'b100100);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Table-driven single frames
        for (int v = 0; v < 8; v++) run_single(tbl[v].dut, tbl[v].data, tbl[v].exp);

        // Pending load during bit 10
        fc = frame_cnt[0]; dc = done_cnt[0];
        pulse_load(0, 10'h123, s);
        repeat (21) @(negedge clk);
        load_r[0] = 1'b1; din_r[0] = 10'h0F0;
        @(negedge clk);
        load_r[0] = 1'b0;
        wait_done(0, dc + 2, 300);
        chk("pend_f1", int'(frame_log[0][fc]), 16'h348C);
        chk("pend_f2", int'(frame_log[0][fc + 1]), 16'h33C0);
        chk("pend_cs_fall", fall_log[0][fc + 1] - done_log[0][dc], 1);

        // Overwrite: last pending strobe wins
        fc = frame_cnt[0]; dc = done_cnt[0];
        pulse_load(0, 10'h0AA, s);
        repeat (10) @(negedge clk);
        load_r[0] = 1'b1; din_r[0] = 10'h001;
        @(negedge clk);
        load_r[0] = 1'b0;
        repeat (10) @(negedge clk);
        load_r[0] = 1'b1; din_r[0] = 10'h3FE;
        @(negedge clk);
        load_r[0] = 1'b0;
        wait_done(0, dc + 2, 300);
        repeat (200) @(negedge clk);
        chk("ovw_f1", int'(frame_log[0][fc]), 16'h32A8);
        chk("ovw_f2", int'(frame_log[0][fc + 1]), 16'h3FF8);
        chk("ovw_frames", frame_cnt[0] - fc, 2);
        chk("ovw_dones", done_cnt[0] - dc, 2);

        // Reset mid-frame at bit 7
        fc = frame_cnt[0]; dc = done_cnt[0];
        pulse_load(0, 10'h2A5, s);
        repeat (33) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid_pins", int'({cs_w[0], sck_w[0], ld_w[0], busy_w[0], done_w[0]}), 5'b10100);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        #1;
        chk("rst_no_done", done_cnt[0] - dc, 0);
        chk("rst_no_frame", frame_cnt[0] - fc, 0);
        chk("rst_ld_idle", int'(ld_w[0]), 1);
        run_single(0, 10'h2A5, 16'h3A94);

        // Randomized strobes against a cycle-level model
        base_f = frame_cnt[0];
        base_d = done_cnt[0];
        busy_until = -1;
        pv = 1'b0;
        pd = '0;
        for (int e = 0; e < 4300; e++) begin
            ld = (e < 4000) && ($urandom_range(0, 99) < 3);
            d  = 10'($urandom_range(0, 1023));
            @(negedge clk);
            load_r[0] = ld;
            din_r[0]  = d;
            // Idle again only after the done edge of the previous frame
            if (e > busy_until) begin
                if (ld) begin
                    eq.push_back(frame_of(0, d));
                    busy_until = e + 68;
                    pv = 1'b0;
                end else if (pv) begin
                    eq.push_back(frame_of(0, pd));
                    busy_until = e + 68;
                    pv = 1'b0;
                end
            end else if (ld) begin
                pv = 1'b1;
                pd = d;
            end
        end
        @(negedge clk);
        load_r[0] = 1'b0;
        #1;
        chk("rnd_frames", frame_cnt[0] - base_f, eq.size());
        chk("rnd_dones", done_cnt[0] - base_d, eq.size());
        for (int j = 0; j < eq.size(); j++) begin
            if (base_f + j < LOGN && base_f + j < frame_cnt[0])
                chk("rnd_frame", int'(frame_log[0][base_f + j]), int'(eq[j]));
        end

        // Periodic operation, default divider
        base_f = frame_cnt[2];
        base_d = done_cnt[2];
        for (int k = 0; k < 10; k++) begin
            d = 10'($urandom_range(0, 1023));
            @(negedge clk);
            chk("per_busy_at_load", int'(busy_w[2]), 0);
            load_r[2] = 1'b1;
            din_r[2]  = d;
            pq.push_back(frame_of(2, d));
            @(negedge clk);
            load_r[2] = 1'b0;
            repeat (4998) @(negedge clk);
        end
        wait_done(2, base_d + 10, 2000);
        #1;
        chk("per_frames", frame_cnt[2] - base_f, 10);
        chk("per_dones", done_cnt[2] - base_d, 10);
        for (int j = 0; j < 10; j++) begin
            if (base_f + j < frame_cnt[2])
                chk("per_frame", int'(frame_log[2][base_f + j]), int'(pq[j]));
        end

        for (int i = 0; i < 3; i++) chk("done_one_cycle", done_long[i], 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
